i2c_adc_target: RTL and testbench

- I2C target (responder) emulating a 16-bit ADC register file at the far end of the on-board I2C master and ADC driver.
- Sits on one I2C bus; the top level builds the open-drain pad from `sdaDriveLow` and the conversion source feeds `convData`/`convBusy`.
- Register map: pointer 0 = conversion (read-only), 1 = config, 2 = lo_thresh, 3 = hi_thresh.
- Used as an in-FPGA ADC model for closed-loop bench and board tests of the controller side.

---
 rtl/i2c_adc_target.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_adc_target.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_adc_target.sv
// I2C target emulating a 16-bit ADC register file (conversion, config, lo/hi threshold).
// Latency: about 3 clk from a pad edge to a response (2-FF sync plus an edge register); SDA is updated on the clk after an SCL fall.
// Backpressure: none, the target never stretches SCL; an address mismatch or a controller NACK parks it until the next START/STOP.
//
// Ports: clk/rst_n (sync active-low); scl/sdaIn raw pad inputs; sdaDriveLow open-drain pull-down;
//        convData/convBusy from the conversion source; startConv/configWrite one-cycle pulses;
//        configOut is the live config register.
module i2c_adc_target #(
    parameter logic [6:0]  ADDRESS      = 7'b1001001,
    parameter logic [15:0] CONFIG_RESET = 16'h8583
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sdaIn,
    output logic        sdaDriveLow,
    input  logic [15:0] convData,
    input  logic        convBusy,
    output logic        startConv,
    output logic [15:0] configOut,
    output logic        configWrite
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_IGNORE, S_PTR, S_WMSB, S_WLSB, S_RDATA
    } state_t;

    state_t      state, state_nxt;
    logic        scl_meta, scl_sync, scl_prev;
    logic        sda_meta, sda_sync, sda_prev;
    logic        scl_rise, scl_fall, bus_start, bus_stop;

    // cnt counts SCL rises within a byte: 0..7 data bits, 8 = ACK slot
    logic [3:0]  cnt, cnt_nxt;
    logic        drive_nxt;
    logic        byte_sel, byte_sel_nxt;   // 0 = MSB byte of snapshot, 1 = LSB byte
    logic        shift_en, ptr_load, msb_load, snap_load, commit;

    logic [7:0]  shift;
    logic [7:0]  msb;
    logic [1:0]  pointer;
    logic [15:0] snap, snap_val;
    logic [15:0] lo_thresh, hi_thresh;
    logic        addr_match;
    logic [3:0]  rd_idx;

    assign scl_rise   = scl_sync & ~scl_prev;
    assign scl_fall   = ~scl_sync & scl_prev;
    assign bus_start  = scl_sync & scl_prev & sda_prev & ~sda_sync;
    assign bus_stop   = scl_sync & scl_prev & ~sda_prev & sda_sync;
    assign addr_match = (shift[7:1] == ADDRESS);
    // byte_sel=0 selects bit 15-cnt, byte_sel=1 selects bit 7-cnt
    assign rd_idx     = {~byte_sel, ~cnt[2:0]};

    always_comb begin
        snap_val = convData;
        case (pointer)
            2'd0:    snap_val = convData;
            2'd1:    snap_val = {~convBusy, configOut[14:0]};
            2'd2:    snap_val = lo_thresh;
            default: snap_val = hi_thresh;
        endcase
    end

    // State, bit counter and SDA drive register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_meta    <= 1'b1;
            scl_sync    <= 1'b1;
            scl_prev    <= 1'b1;
            sda_meta    <= 1'b1;
            sda_sync    <= 1'b1;
            sda_prev    <= 1'b1;
            state       <= S_IDLE;
            cnt         <= 4'd0;
            sdaDriveLow <= 1'b0;
            byte_sel    <= 1'b0;
        end else begin
            scl_meta    <= scl;
            scl_sync    <= scl_meta;
            scl_prev    <= scl_sync;
            sda_meta    <= sdaIn;
            sda_sync    <= sda_meta;
            sda_prev    <= sda_sync;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            sdaDriveLow <= drive_nxt;
            byte_sel    <= byte_sel_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        drive_nxt    = sdaDriveLow;
        byte_sel_nxt = byte_sel;
        shift_en     = 1'b0;
        ptr_load     = 1'b0;
        msb_load     = 1'b0;
        snap_load    = 1'b0;
        commit       = 1'b0;

        if (bus_stop) begin
            state_nxt = S_IDLE;
            cnt_nxt   = 4'd0;
            drive_nxt = 1'b0;
        end else if (bus_start) begin
            state_nxt    = S_ADDR;
            cnt_nxt      = 4'd0;
            drive_nxt    = 1'b0;
            byte_sel_nxt = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_PTR, S_WMSB, S_WLSB: begin
                    if (scl_rise) begin
                        if (cnt != 4'd8) begin
                            shift_en = 1'b1;
                            cnt_nxt  = cnt + 4'd1;
                        end else begin
                            // 9th rise: the byte and its ACK are complete
                            cnt_nxt = 4'd0;
                            case (state)
                                S_ADDR: begin
                                    if (!addr_match) begin
                                        state_nxt = S_IGNORE;
                                    end else if (shift[0]) begin
                                        state_nxt    = S_RDATA;
                                        snap_load    = 1'b1;
                                        byte_sel_nxt = 1'b0;
                                    end else begin
                                        state_nxt = S_PTR;
                                    end
                                end
                                S_PTR: begin
                                    ptr_load  = 1'b1;
                                    state_nxt = S_WMSB;
                                end
                                S_WMSB: begin
                                    msb_load  = 1'b1;
                                    state_nxt = S_WLSB;
                                end
                                default: begin
                                    commit    = 1'b1;
                                    state_nxt = S_WMSB;
                                end
                            endcase
                        end
                    end else if (scl_fall) begin
                        // pull low only for the ACK slot; released on the fall that ends it
                        drive_nxt = (cnt == 4'd8) && ((state != S_ADDR) || addr_match);
                    end
                end
                S_RDATA: begin
                    if (scl_rise) begin
                        if (cnt != 4'd8) begin
                            cnt_nxt = cnt + 4'd1;
                        end else begin
                            cnt_nxt = 4'd0;
                            if (!sda_sync) begin
                                // controller ACK: next byte; after the LSB, refresh and wrap
                                byte_sel_nxt = ~byte_sel;
                                snap_load    = byte_sel;
                            end else begin
                                state_nxt = S_IGNORE;
                            end
                        end
                    end else if (scl_fall) begin
                        drive_nxt = (cnt != 4'd8) && ~snap[rd_idx];
                    end
                end
                default: begin
                    drive_nxt = 1'b0;
                end
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift       <= 8'd0;
            msb         <= 8'd0;
            pointer     <= 2'd0;
            snap        <= 16'd0;
            lo_thresh   <= 16'h8000;
            hi_thresh   <= 16'h7FFF;
            configOut   <= CONFIG_RESET;
            configWrite <= 1'b0;
            startConv   <= 1'b0;
        end else begin
            configWrite <= 1'b0;
            startConv   <= 1'b0;
            if (shift_en)  shift   <= {shift[6:0], sda_sync};
            if (ptr_load)  pointer <= shift[1:0];
            if (msb_load)  msb     <= shift;
            if (snap_load) snap    <= snap_val;
            if (commit) begin
                case (pointer)
                    2'd1: begin
                        // bit15 is a start-conversion strobe, never stored
                        configOut   <= {1'b0, msb[6:0], shift};
                        configWrite <= 1'b1;
                        startConv   <= msb[7];
                    end
                    2'd2:    lo_thresh <= {msb, shift};
                    2'd3:    hi_thresh <= {msb, shift};
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_adc_target.sv
// Bench for i2c_adc_target: bit-banged I2C controller over an open-drain line model.
// Expected ACKs and read bytes are queued before each byte and checked when it completes.
module tb_i2c_adc_target;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl;
    logic        sda_ctl_low;
    logic        sda_line;
    logic        sdaDriveLow;
    logic [15:0] convData;
    logic        convBusy;
    logic        startConv;
    logic [15:0] configOut;
    logic        configWrite;

    int n_cmp = 0;
    int n_bad = 0;
    int cw_cnt = 0;
    int sc_cnt = 0;
    int drive_hits = 0;
    logic [31:0] exp_q[$];

    assign sda_line = ~(sda_ctl_low | sdaDriveLow);

    always #5 clk = ~clk;

    i2c_adc_target dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl         (scl),
        .sdaIn       (sda_line),
        .sdaDriveLow (sdaDriveLow),
        .convData    (convData),
        .convBusy    (convBusy),
        .startConv   (startConv),
        .configOut   (configOut),
        .configWrite (configWrite)
    );

    always @(negedge clk) begin
        if (configWrite) cw_cnt++;
        if (startConv)   sc_cnt++;
        if (sdaDriveLow) drive_hits++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = 32'hDEAD_BEEF;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk_eq(tag, obs, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b, output logic seen);
        sda_ctl_low = ~b;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        @(negedge clk);
        seen = sda_line;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_start();
        sda_ctl_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_ctl_low = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        sda_ctl_low = 1'b0;
        tick(2 * Q);
    endtask

    task automatic wr(input string tag, input logic [7:0] b, input logic exp_ack);
        logic s;
        push_exp({31'd0, exp_ack});
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        pop_chk(tag, {31'd0, ~s});
    endtask

    task automatic rd(input string tag, input logic ack, input logic [7:0] exp);
        logic       s;
        logic [7:0] d;
        push_exp({24'd0, exp});
        d = 8'd0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(~ack, s);
        pop_chk(tag, {24'd0, d});
    endtask

    int cw0, sc0, h0;

    initial begin
        scl         = 1'b1;
        sda_ctl_low = 1'b0;
        rst_n       = 1'b0;
        convData    = 16'h1234;
        convBusy    = 1'b0;
        tick(4);
        @(negedge clk);
        chk_eq("rst_sda",    {31'd0, sdaDriveLow}, 32'd0);
        chk_eq("rst_cfg",    {16'd0, configOut},   32'h8583);
        chk_eq("rst_cfgwr",  {31'd0, configWrite}, 32'd0);
        chk_eq("rst_start",  {31'd0, startConv},   32'd0);
        rst_n = 1'b1;
        tick(4);

        // config write with start-conversion bit set
        cw0 = cw_cnt; sc0 = sc_cnt;
        i2c_start();
        wr("cfg_addr", 8'h92, 1'b1);
        wr("cfg_ptr",  8'h01, 1'b1);
        wr("cfg_msb",  8'h85, 1'b1);
        wr("cfg_lsb",  8'h83, 1'b1);
        i2c_stop();
        @(negedge clk);
        chk_eq("cfg_val",    {16'd0, configOut}, 32'h0583);
        chk_eq("cfg_wr_cnt", cw_cnt - cw0, 32'd1);
        chk_eq("cfg_sc_cnt", sc_cnt - sc0, 32'd1);

        // conversion read via pointer-only write
        i2c_start();
        wr("p0_addr", 8'h92, 1'b1);
        wr("p0_ptr",  8'h00, 1'b1);
        i2c_stop();
        i2c_start();
        wr("conv_addr", 8'h93, 1'b1);
        rd("conv_msb", 1'b1, 8'h12);
        rd("conv_lsb", 1'b0, 8'h34);
        @(negedge clk);
        chk_eq("conv_rel", {31'd0, sdaDriveLow}, 32'd0);
        i2c_stop();

        // busy flag readback and MSB/LSB wrap
        i2c_start();
        wr("p1_addr", 8'h92, 1'b1);
        wr("p1_ptr",  8'h01, 1'b1);
        i2c_stop();
        convBusy = 1'b1;
        i2c_start();
        wr("busy_addr", 8'h93, 1'b1);
        rd("busy_msb",  1'b1, 8'h05);
        rd("busy_lsb",  1'b1, 8'h83);
        rd("busy_wrap", 1'b0, 8'h05);
        i2c_stop();
        convBusy = 1'b0;
        i2c_start();
        wr("idle_addr", 8'h93, 1'b1);
        rd("idle_msb",  1'b0, 8'h85);
        i2c_stop();

        // wrong address is ignored entirely
        cw0 = cw_cnt; h0 = drive_hits;
        i2c_start();
        wr("bad_addr", 8'h90, 1'b0);
        wr("bad_b1",   8'h01, 1'b0);
        wr("bad_b2",   8'h00, 1'b0);
        i2c_stop();
        @(negedge clk);
        chk_eq("bad_drive", drive_hits - h0, 32'd0);
        chk_eq("bad_cfg",   {16'd0, configOut}, 32'h0583);
        chk_eq("bad_cfgwr", cw_cnt - cw0, 32'd0);

        // repeated start after a half-written pair leaves lo_thresh alone
        i2c_start();
        wr("rs_addr", 8'h92, 1'b1);
        wr("rs_ptr",  8'h02, 1'b1);
        wr("rs_msb",  8'hAA, 1'b1);
        i2c_start();
        wr("rs_raddr", 8'h93, 1'b1);
        rd("lo_msb", 1'b1, 8'h80);
        rd("lo_lsb", 1'b0, 8'h00);
        i2c_stop();

        // hi_thresh write and readback
        i2c_start();
        wr("hi_addr", 8'h92, 1'b1);
        wr("hi_ptr",  8'h03, 1'b1);
        wr("hi_msb",  8'h12, 1'b1);
        wr("hi_lsb",  8'h34, 1'b1);
        i2c_stop();
        i2c_start();
        wr("hi_raddr", 8'h93, 1'b1);
        rd("hi_rmsb", 1'b1, 8'h12);
        rd("hi_rlsb", 1'b0, 8'h34);
        i2c_stop();

        // reset while the target is driving a 0 data bit
        i2c_start();
        wr("mr_addr", 8'h93, 1'b1);
        @(negedge clk);
        chk_eq("mr_drive0", {31'd0, sdaDriveLow}, 32'd1);
        @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_eq("mr_rel", {31'd0, sdaDriveLow}, 32'd0);
        chk_eq("mr_cfg", {16'd0, configOut},   32'h8583);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        i2c_start();
        wr("post_addr", 8'h93, 1'b1);
        rd("post_msb", 1'b1, 8'h12);
        rd("post_lsb", 1'b0, 8'h34);
        i2c_stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
